// File: rtl/hqc_msg_serializer.sv
// Captures the HQC decoded message in one cycle and streams it as 64-bit words over valid/ready.
// Optional HQC_MSG_SER_CLEAR_EN: zeroize holding register after last transfer and on flush_i.
module hqc_msg_serializer #(
  parameter int PARAM_SECURITY = 128,
  parameter int PARAM_K        = (PARAM_SECURITY == 128) ? 16 :
                                 (PARAM_SECURITY == 192) ? 24 :
                                 (PARAM_SECURITY == 256) ? 32 : 31,
  parameter int DIN_W          = 8 * PARAM_K,
  parameter int DOUT_W         = 64,
  parameter int NWORDS         = (PARAM_K + 7) / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DIN_W-1:0]  din_i,
  input  logic              din_valid_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic [DOUT_W-1:0] dout_o,
  output logic [7:0]        dout_keep_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic              dout_last_o,
  output logic              ovf_o
);

  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  // Pad to a power-of-two word count so every idx value selects in range.
  localparam int PAD_W = (1 << IDX_W) * DOUT_W;
  localparam int REM   = PARAM_K % 8;
  localparam logic [7:0] LAST_KEEP = (REM == 0) ? 8'hFF : 8'((1 << REM) - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [DIN_W-1:0] hold;
  logic [PAD_W-1:0] hold_pad;
  logic             ovf;
  logic             xfer;
  logic             last_word;

  assign last_word = (idx == IDX_W'(NWORDS - 1));
  assign xfer      = (state == SEND) && dout_ready_i;
  assign hold_pad  = PAD_W'(hold);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (din_valid_i)        state_nxt = SEND;
        SEND:    if (xfer && last_word)  state_nxt = IDLE;
        default:                         state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o       = (state == SEND);
    dout_valid_o = busy_o;
    dout_o       = '0;
    dout_keep_o  = 8'h00;
    dout_last_o  = 1'b0;
    if (busy_o) begin
      dout_o      = hold_pad[idx*DOUT_W +: DOUT_W];
      dout_keep_o = last_word ? LAST_KEEP : 8'hFF;
      dout_last_o = last_word;
    end
  end

  assign ovf_o = ovf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx <= '0;
      ovf <= 1'b0;
    end else if (flush_i) begin
      idx <= '0;
      ovf <= 1'b0;
    end else begin
      if (state == IDLE && din_valid_i) idx <= '0;
      else if (xfer)                    idx <= last_word ? '0 : idx + 1'b1;
      // A pulse during SEND (including the last-transfer cycle) is dropped and flagged.
      if (state == SEND && din_valid_i) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold <= '0;
    end else if (flush_i) begin
`ifdef HQC_MSG_SER_CLEAR_EN
      hold <= '0;
`else
      hold <= hold;
`endif
    end else if (state == IDLE && din_valid_i) begin
      hold <= din_i;
    end else if (xfer && last_word) begin
`ifdef HQC_MSG_SER_CLEAR_EN
      hold <= '0;
`else
      hold <= hold;
`endif
    end
  end

endmodule

// File: doc/hqc_msg_serializer.md
# hqc_msg_serializer

Downstream stage of the HQC decoder: captures the PARAM_K-byte message emitted in one pulse by the RM/RS decoding top and streams it as 64-bit words over a valid/ready handshake to the decapsulation hash (G-function) input. It decouples the decoder's single-cycle parallel result from a backpressured consumer and reports any message that arrives while the previous one is still draining.

## Interface
- PARAM_SECURITY, 128, security level; selects PARAM_K
- PARAM_K, 16/24/32 for 128/192/256, 31 otherwise; message length in bytes
- DIN_W, 8*PARAM_K, parallel message width
- DOUT_W, 64, stream word width (fixed)
- NWORDS, ceil(PARAM_K/8), words per message
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- din_i  in  DIN_W  message {m[K-1],...,m[0]}, byte m[i] at bits 8i+7:8i
- din_valid_i  in  1  one-cycle pulse, din_i valid
- flush_i  in  1  synchronous abort of current message
- busy_o  out  1  message held, not fully drained
- dout_o  out  DOUT_W  stream word
- dout_keep_o  out  8  byte enables of dout_o
- dout_valid_o  out  1  word valid
- dout_ready_i  in  1  consumer accepts word
- dout_last_o  out  1  final word of message
- ovf_o  out  1  sticky: din_valid_i seen while busy

## Operation
- States: IDLE, SEND.
- IDLE: din_valid_i=1 -> load din_i into holding register, word index idx=0, go SEND.
- SEND: dout_o = holding bytes [8*idx+7 : 8*idx] (byte m[8*idx] in bits 7:0); bytes beyond PARAM_K read 0.
- dout_keep_o = 8'hFF except on last word when PARAM_K%8!=0: (1<<(PARAM_K%8))-1 (K=31 -> 8'h7F).
- dout_last_o = (idx == NWORDS-1) while in SEND; 0 otherwise.
- Transfer = dout_valid_o & dout_ready_i. On transfer: idx+1; on transfer of last word: go IDLE.
- din_valid_i in SEND: ignored (holding register unchanged), ovf_o set; ovf_o cleared only by reset or flush_i.
- flush_i=1: go IDLE, idx=0, ovf_o=0; takes priority over transfer and din_valid_i in the same cycle.
- din_valid_i in the cycle the last word transfers: treated as overflow (state still SEND at that edge); not captured.
- idx width clog2(NWORDS), minimum 1; never wraps (leaves SEND at NWORDS-1).

## Timing
- Reset values: busy_o=0, dout_o=0, dout_keep_o=0, dout_valid_o=0, dout_last_o=0, ovf_o=0, state IDLE, idx=0, holding register 0.
- Latency: din_valid_i at edge N -> dout_valid_o=1 and word 0 on dout_o after edge N (visible cycle N+1).
- With dout_ready_i held 1: one word per cycle, NWORDS cycles; busy_o falls in the cycle after the last transfer edge.
- dout_valid_o, dout_o, dout_keep_o, dout_last_o stable while valid=1 and ready=0 (AXI-Stream rule); valid never drops without transfer except on flush_i/reset.
- dout_ready_i may be asserted before valid; it has no effect in IDLE.
- busy_o = (state == SEND); dout_valid_o = busy_o.
- dout_o/keep/last may be combinational from registered state and holding register; no path from dout_ready_i to any output.
- Reset asserted mid-message: all outputs to reset values immediately (asynchronous), message discarded.

## Configuration
- HQC_MSG_SER_CLEAR_EN defined: holding register zeroized on the edge the last word transfers and on flush_i (message does not persist after consumption).
- Undefined: holding register retains the last message until next capture; no other behaviour differs, stream output identical.

## Test plan
- PARAM_SECURITY=128, din_i=128'h0F0E..0100 (m[i]=i), ready=1 -> 2 words 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, keep FF/FF, last on word 1, busy 2 cycles.
- PARAM_SECURITY=0 (K=31), m[i]=i+1, ready=1 -> 4 words, word 3 = 64'h001F1E1D1C1B1A19, keep 8'h7F, last=1.
- PARAM_SECURITY=256, ready toggling 1,0,0,1,... -> 4 words in order, outputs stable during ready=0, no word dropped or duplicated.
- Second din_valid_i pulse while word 1 of 3 (K=24) pending -> ovf_o=1, stream still delivers first message unchanged; flush_i -> ovf_o=0, IDLE.
- flush_i and a transfer in the same cycle -> IDLE next cycle, idx=0; new din_valid_i afterwards restarts at word 0.
- rst_ni low mid-stream -> outputs 0 asynchronously; with HQC_MSG_SER_CLEAR_EN, holding register reads 0 after last transfer (probe internal), without it retains message.
